// File: rtl/quire_to_posit.sv
// Quire fixed-point word to rounded posit, three-stage pipeline with rts/rtr/sow/eow handshake.
// Optional saturation counter port sat_count_o when QUIRE2POSIT_SAT_STATS_EN is defined.
module quire_to_posit #(
    parameter int unsigned POSIT_WIDTH     = 8,
    parameter int unsigned POSIT_ES        = 2,
    parameter int unsigned QUIRE_WIDTH     = 128,
    parameter int unsigned QUIRE_FRAC_BITS = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rts_i,
    output logic                   rtr_o,
    input  logic                   sow_i,
    input  logic                   eow_i,
    input  logic [QUIRE_WIDTH-1:0] data_i,
    input  logic                   rtr_i,
`ifdef QUIRE2POSIT_SAT_STATS_EN
    output logic [15:0]            sat_count_o,
`endif
    output logic                   rts_o,
    output logic                   sow_o,
    output logic                   eow_o,
    output logic [POSIT_WIDTH-1:0] posit_o
);

    localparam int unsigned N   = POSIT_WIDTH;
    localparam int unsigned ES  = POSIT_ES;
    localparam int unsigned MW  = QUIRE_WIDTH - 1;
    localparam int unsigned PW  = $clog2(MW);
    localparam int unsigned VW  = 32;
    localparam logic signed [15:0] MAX_SCALE = 16'((N - 2) << ES);
    localparam logic signed [15:0] MIN_SCALE = -MAX_SCALE;

    // Handshake / stage control
    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_ready, s2_ready, s3_ready;

    assign s3_ready = ~s3_valid_q | rtr_i;
    assign s2_ready = ~s2_valid_q | s3_ready;
    assign s1_ready = ~s1_valid_q | s2_ready;
    assign rtr_o    = s1_ready;

    // Stage 1: flags and magnitude
    logic          s1_nar_q, s1_zero_q, s1_sign_q, s1_sow_q, s1_eow_q;
    logic [MW-1:0] s1_mag_q;
    logic          s1_nar_d, s1_zero_d;
    logic [MW-1:0] s1_mag_d;

    always_comb begin
        s1_nar_d  = (data_i == {1'b1, {(QUIRE_WIDTH-1){1'b0}}});
        s1_zero_d = (data_i == '0);
        s1_mag_d  = data_i[QUIRE_WIDTH-1] ? (~data_i[MW-1:0] + 1'b1) : data_i[MW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_sow_q   <= 1'b0;
            s1_eow_q   <= 1'b0;
            s1_mag_q   <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= rts_i;
            s1_nar_q   <= s1_nar_d;
            s1_zero_q  <= s1_zero_d;
            s1_sign_q  <= data_i[QUIRE_WIDTH-1];
            s1_sow_q   <= sow_i;
            s1_eow_q   <= eow_i;
            s1_mag_q   <= s1_mag_d;
        end
    end

    // Stage 2: leading-one detect and fraction extract
    logic [PW-1:0]      lo_pos;
    logic [PW-1:0]      shamt;
    logic [MW-1:0]      norm;
    logic signed [15:0] s2_scale_d;
    logic [N-1:0]       s2_frac_d;
    logic               s2_sticky_d;

    always_comb begin
        lo_pos = '0;
        for (int i = 0; i < int'(MW); i++) begin
            if (s1_mag_q[i]) lo_pos = PW'(i);
        end
        shamt       = PW'(MW - 1) - lo_pos;
        norm        = s1_mag_q << shamt;
        s2_frac_d   = norm[MW-2 -: N];
        s2_sticky_d = |norm[MW-2-N:0];
        s2_scale_d  = 16'(lo_pos) - 16'(QUIRE_FRAC_BITS);
    end

    logic               s2_nar_q, s2_zero_q, s2_sign_q, s2_sow_q, s2_eow_q, s2_sticky_q;
    logic signed [15:0] s2_scale_q;
    logic [N-1:0]       s2_frac_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_nar_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_sow_q    <= 1'b0;
            s2_eow_q    <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_scale_q  <= '0;
            s2_frac_q   <= '0;
        end else if (s2_ready) begin
            s2_valid_q  <= s1_valid_q;
            s2_nar_q    <= s1_nar_q;
            s2_zero_q   <= s1_zero_q;
            s2_sign_q   <= s1_sign_q;
            s2_sow_q    <= s1_sow_q;
            s2_eow_q    <= s1_eow_q;
            s2_sticky_q <= s2_sticky_d;
            s2_scale_q  <= s2_scale_d;
            s2_frac_q   <= s2_frac_d;
        end
    end

    // Stage 3: regime/exponent encode, round to nearest even, apply sign
    logic [5:0]    k6;
    logic [5:0]    rl;
    logic [ES-1:0] e_bits;
    logic [VW-1:0] regime_v, payload, body;
    logic [N-2:0]  mag_t, mag_out;
    logic          guard, stk, sat_d;
    logic [N-1:0]  mag_rnd, s3_posit_d;

    always_comb begin
        k6     = 6'(s2_scale_q >>> ES);
        e_bits = s2_scale_q[ES-1:0];
        if (!s2_scale_q[15]) begin
            regime_v = ~({VW{1'b1}} >> (k6 + 6'd1));
            rl       = k6 + 6'd2;
        end else begin
            regime_v = {1'b1, {(VW-1){1'b0}}} >> (-k6);
            rl       = 6'd1 - k6;
        end
        payload = {e_bits, s2_frac_q, {(VW-ES-N){1'b0}}};
        body    = regime_v | (payload >> rl);
        mag_t   = body[VW-1 -: N-1];
        guard   = body[VW-N];
        stk     = (|body[VW-N-1:0]) | s2_sticky_q;
        mag_rnd = {1'b0, mag_t} + N'(guard & (stk | mag_t[0]));

        sat_d = 1'b0;
        if (s2_scale_q >= MAX_SCALE) begin
            mag_out = '1;
            sat_d   = 1'b1;
        end else if (s2_scale_q < MIN_SCALE) begin
            mag_out = (N-1)'(1);
            sat_d   = 1'b1;
        end else if (mag_rnd[N-1]) begin
            mag_out = '1;
        end else if (mag_rnd == '0) begin
            mag_out = (N-1)'(1);
        end else begin
            mag_out = mag_rnd[N-2:0];
        end

        if (s2_nar_q) begin
            s3_posit_d = {1'b1, {(N-1){1'b0}}};
            sat_d      = 1'b0;
        end else if (s2_zero_q) begin
            s3_posit_d = '0;
            sat_d      = 1'b0;
        end else if (s2_sign_q) begin
            s3_posit_d = -{1'b0, mag_out};
        end else begin
            s3_posit_d = {1'b0, mag_out};
        end
    end

    logic         s3_sow_q, s3_eow_q, s3_sat_q;
    logic [N-1:0] s3_posit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_sow_q   <= 1'b0;
            s3_eow_q   <= 1'b0;
            s3_sat_q   <= 1'b0;
            s3_posit_q <= '0;
        end else if (s3_ready) begin
            s3_valid_q <= s2_valid_q;
            s3_sow_q   <= s2_sow_q;
            s3_eow_q   <= s2_eow_q;
            s3_sat_q   <= sat_d;
            s3_posit_q <= s3_posit_d;
        end
    end

    always_comb begin
        rts_o   = s3_valid_q;
        sow_o   = s3_sow_q;
        eow_o   = s3_eow_q;
        posit_o = s3_posit_q;
    end

`ifdef QUIRE2POSIT_SAT_STATS_EN
    logic [15:0] sat_count_q, sat_count_d;

    always_comb begin
        sat_count_d = sat_count_q;
        if (s3_valid_q && rtr_i) begin
            if (s3_sow_q) begin
                sat_count_d = {15'd0, s3_sat_q};
            end else if (s3_sat_q && (sat_count_q != 16'hFFFF)) begin
                sat_count_d = sat_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_count_q <= '0;
        else     sat_count_q <= sat_count_d;
    end

    assign sat_count_o = sat_count_q;
`else
    logic unused_sat;
    assign unused_sat = s3_sat_q;
`endif

endmodule

// File: tb/tb_quire_to_posit.sv
// Directed self-checking bench for quire_to_posit (N=8, ES=2, QUIRE_WIDTH=128, FRAC=48).
// Also exercises sat_count_o when QUIRE2POSIT_SAT_STATS_EN is defined.
module tb_quire_to_posit;

    logic         tb_clk = 1'b0;
    logic         tb_reset_n = 1'b0;
    logic         rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0, rtr_i = 1'b0;
    logic [127:0] data_i = '0;
    logic         rtr_o, rts_o, sow_o, eow_o;
    logic [7:0]   posit_o;
`ifdef QUIRE2POSIT_SAT_STATS_EN
    logic [15:0]  sat_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 tb_clk = ~tb_clk;

    quire_to_posit #(
        .POSIT_WIDTH    (8),
        .POSIT_ES       (2),
        .QUIRE_WIDTH    (128),
        .QUIRE_FRAC_BITS(48)
    ) dut (
        .clk        (tb_clk),
        .rst        (~tb_reset_n),
        .rts_i      (rts_i),
        .rtr_o      (rtr_o),
        .sow_i      (sow_i),
        .eow_i      (eow_i),
        .data_i     (data_i),
        .rtr_i      (rtr_i),
`ifdef QUIRE2POSIT_SAT_STATS_EN
        .sat_count_o(sat_count),
`endif
        .rts_o      (rts_o),
        .sow_o      (sow_o),
        .eow_o      (eow_o),
        .posit_o    (posit_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [127:0] vec_d [15];
    logic [7:0]   vec_p [15];

    // One isolated word through an empty pipe; latency counted in cycles from the accept cycle.
    task automatic send_one(input string tag, input logic [127:0] d, input logic sw,
                            input logic ew, input logic [7:0] exp);
        int n;
        @(negedge tb_clk);
        rts_i  = 1'b1;
        data_i = d;
        sow_i  = sw;
        eow_i  = ew;
        rtr_i  = 1'b1;
        #1;
        check_eq({tag, "_rtr"}, {31'd0, rtr_o}, 32'd1);
        @(posedge tb_clk);
        @(negedge tb_clk);
        rts_i = 1'b0;
        sow_i = 1'b0;
        eow_i = 1'b0;
        n = 1;
        while (!rts_o && n < 10) begin
            @(negedge tb_clk);
            n++;
        end
        check_eq({tag, "_lat"}, n, 32'd3);
        check_eq(tag, {24'd0, posit_o}, {24'd0, exp});
        check_eq({tag, "_sow"}, {31'd0, sow_o}, {31'd0, sw});
        check_eq({tag, "_eow"}, {31'd0, eow_o}, {31'd0, ew});
        @(posedge tb_clk);
    endtask

    initial begin
        int  in_idx, out_idx, cyc, extra;
        bit  acc, saw_block;

        vec_d[0]  = 128'd1 << 48;                       vec_p[0]  = 8'h40;
        vec_d[1]  = ~(128'd1 << 48) + 128'd1;           vec_p[1]  = 8'hC0;
        vec_d[2]  = 128'd3 << 47;                       vec_p[2]  = 8'h44;
        vec_d[3]  = 128'd0;                             vec_p[3]  = 8'h00;
        vec_d[4]  = 128'd1 << 127;                      vec_p[4]  = 8'h80;
        vec_d[5]  = 128'd1 << 108;                      vec_p[5]  = 8'h7F;
        vec_d[6]  = 128'd1;                             vec_p[6]  = 8'h01;
        vec_d[7]  = ~(128'd1 << 108) + 128'd1;          vec_p[7]  = 8'h81;
        vec_d[8]  = {128{1'b1}};                        vec_p[8]  = 8'hFF;
        vec_d[9]  = (128'd1 << 48) | (128'd1 << 44);    vec_p[9]  = 8'h40;
        vec_d[10] = (128'd1 << 48) | (128'd1 << 44) | (128'd1 << 40);
        vec_p[10] = 8'h41;
        vec_d[11] = (128'd1 << 48) | (128'd3 << 44);    vec_p[11] = 8'h42;
        vec_d[12] = 128'd1 << 71;                       vec_p[12] = 8'h7F;
        vec_d[13] = 128'd1 << 28;                       vec_p[13] = 8'h02;
        vec_d[14] = 128'd1 << 24;                       vec_p[14] = 8'h01;

        repeat (3) @(negedge tb_clk);
        check_eq("rst_rts", {31'd0, rts_o}, 32'd0);
        check_eq("rst_rtr", {31'd0, rtr_o}, 32'd1);
        check_eq("rst_posit", {24'd0, posit_o}, 32'd0);
        check_eq("rst_sow_eow", {30'd0, sow_o, eow_o}, 32'd0);
        tb_reset_n = 1'b1;
        repeat (2) @(negedge tb_clk);

        for (int i = 0; i < 15; i++) begin
            send_one($sformatf("single%0d", i), vec_d[i], 1'b0, 1'b0, vec_p[i]);
        end
        send_one("single_sow_eow", vec_d[2], 1'b1, 1'b1, vec_p[2]);

`ifdef QUIRE2POSIT_SAT_STATS_EN
        send_one("sat_nar", vec_d[4], 1'b1, 1'b0, vec_p[4]);
        send_one("sat_max", vec_d[5], 1'b0, 1'b0, vec_p[5]);
        send_one("sat_min", vec_d[6], 1'b0, 1'b0, vec_p[6]);
        @(negedge tb_clk);
        check_eq("sat_count", {16'd0, sat_count}, 32'd2);
`endif

        // Back-to-back stream with rtr_i pattern 1,0,0 repeating
        in_idx    = 0;
        out_idx   = 0;
        cyc       = 0;
        saw_block = 1'b0;
        while (out_idx < 10 && cyc < 300) begin
            @(negedge tb_clk);
            rtr_i  = (cyc % 3 == 0);
            rts_i  = (in_idx < 10);
            data_i = (in_idx < 10) ? vec_d[in_idx] : 128'd0;
            sow_i  = (in_idx == 0);
            eow_i  = (in_idx == 9);
            #1;
            if (!rtr_o) saw_block = 1'b1;
            if (rts_o) begin
                check_eq($sformatf("stream%0d", out_idx), {24'd0, posit_o},
                         {24'd0, vec_p[out_idx]});
                if (rtr_i) begin
                    check_eq($sformatf("stream_sow%0d", out_idx), {31'd0, sow_o},
                             {31'd0, out_idx == 0});
                    check_eq($sformatf("stream_eow%0d", out_idx), {31'd0, eow_o},
                             {31'd0, out_idx == 9});
                    out_idx++;
                end
            end
            acc = rts_i && rtr_o;
            @(posedge tb_clk);
            if (acc) in_idx++;
            cyc++;
        end
        @(negedge tb_clk);
        rts_i = 1'b0;
        sow_i = 1'b0;
        eow_i = 1'b0;
        rtr_i = 1'b1;
        check_eq("stream_count", out_idx, 32'd10);
        check_eq("stream_backpressure", {31'd0, saw_block}, 32'd1);
        extra = 0;
        repeat (6) begin
            #1;
            if (rts_o) extra++;
            @(negedge tb_clk);
        end
        check_eq("stream_no_dup", extra, 32'd0);

        // Reset with words in flight
        rts_i  = 1'b1;
        data_i = vec_d[0];
        @(posedge tb_clk);
        @(negedge tb_clk);
        data_i = vec_d[5];
        @(posedge tb_clk);
        @(negedge tb_clk);
        rts_i = 1'b0;
        rtr_i = 1'b0;
        @(posedge tb_clk);
        @(negedge tb_clk);
        check_eq("inflight_rts", {31'd0, rts_o}, 32'd1);
        tb_reset_n = 1'b0;
        #1;
        check_eq("midrst_rts", {31'd0, rts_o}, 32'd0);
        check_eq("midrst_posit", {24'd0, posit_o}, 32'd0);
`ifdef QUIRE2POSIT_SAT_STATS_EN
        check_eq("midrst_sat", {16'd0, sat_count}, 32'd0);
`endif
        @(negedge tb_clk);
        tb_reset_n = 1'b1;
        rtr_i      = 1'b1;
        extra      = 0;
        repeat (8) begin
            #1;
            if (rts_o) extra++;
            @(negedge tb_clk);
        end
        check_eq("postrst_quiet", extra, 32'd0);
        send_one("postrst_word", vec_d[11], 1'b0, 1'b0, vec_p[11]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
